// File: rtl/coherence_pkg.sv
// Shared types and default widths for the snooping coherence bus.
package coherence_pkg;

  localparam int unsigned DEF_N_CORES = 4;
  localparam int unsigned DEF_ADDR_W  = 8;
  localparam int unsigned DEF_TIMEOUT = 16;

  typedef enum logic [1:0] {
    READ_MISS  = 2'b00,
    WRITE_MISS = 2'b01,
    INVALIDATE = 2'b10,
    WRITE_BACK = 2'b11
  } bus_op_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SNOOP = 2'b01,
    ST_MEM   = 2'b10,
    ST_DONE  = 2'b11
  } bus_state_t;

  // Core-index width; a single-core bus still carries a 1-bit index.
  function automatic int unsigned src_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// N-way round-robin arbiter: priority starts at the core after i_last.
module rr_arbiter #(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = 2
) (
  input  logic [N-1:0]     i_req,
  input  logic [IDX_W-1:0] i_last,
  output logic [N-1:0]     o_grant_c
);

  int w_idx;

  // Scan from the farthest offset down so the nearest requester wins.
  always_comb begin
    o_grant_c = '0;
    w_idx     = 0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      w_idx = (int'(i_last) + 1 + i) % int'(N);
      if (i_req[IDX_W'(w_idx)]) begin
        o_grant_c = N'(1) << w_idx;
      end
    end
  end

endmodule

// File: rtl/coherence_bus.sv
// Snooping coherence bus: arbitrates core requests, broadcasts snoops, drives memory.
// Optional snoop timeout enabled by defining COHBUS_TIMEOUT_EN.
module coherence_bus
  import coherence_pkg::*;
#(
  parameter  int unsigned N_CORES = DEF_N_CORES,
  parameter  int unsigned ADDR_W  = DEF_ADDR_W,
  parameter  int unsigned TIMEOUT = DEF_TIMEOUT,
  localparam int unsigned SRC_W   = src_width(N_CORES)
) (
  input  logic                      i_clock,
  input  logic                      i_reset,
  input  logic [N_CORES-1:0]        i_req_valid,
  input  logic [2*N_CORES-1:0]      i_req_type,
  input  logic [ADDR_W*N_CORES-1:0] i_req_addr,
  output logic [N_CORES-1:0]        o_req_grant,
  output logic [N_CORES-1:0]        o_req_done,
  output logic                      o_snoop_valid,
  output logic [1:0]                o_snoop_type,
  output logic [ADDR_W-1:0]         o_snoop_addr,
  output logic [SRC_W-1:0]          o_snoop_src,
  input  logic [N_CORES-1:0]        i_snoop_ack,
  input  logic [N_CORES-1:0]        i_snoop_abort,
  output logic                      o_mem_req,
  output logic                      o_mem_write,
  output logic [ADDR_W-1:0]         o_mem_addr,
  input  logic                      i_mem_done,
  output logic                      o_bus_busy,
  output logic                      o_timeout_err
);

  bus_state_t          r_state, w_next;
  logic [SRC_W-1:0]    r_src, r_last, w_pick_idx;
  bus_op_t             r_op, w_pick_op;
  logic [ADDR_W-1:0]   r_addr, w_pick_addr;
  logic [N_CORES-1:0]  r_ack, r_abort, w_grant, w_src_mask;
  logic                w_req_any, w_ack_all, w_abort_any, w_snoop_exit, w_timeout;
  logic                w_mem_write_nxt;
  logic [ADDR_W-1:0]   w_mem_addr_nxt;

  logic [N_CORES-1:0]  r_grant, r_done;
  logic                r_snoop_valid, r_mem_req, r_mem_write, r_busy;
  logic [ADDR_W-1:0]   r_mem_addr;

  rr_arbiter #(
    .N     (N_CORES),
    .IDX_W (SRC_W)
  ) u_arb (
    .i_req     (i_req_valid),
    .i_last    (r_last),
    .o_grant_c (w_grant)
  );

  // Decode the winning core's index, op and address.
  always_comb begin
    w_pick_idx  = '0;
    w_pick_op   = READ_MISS;
    w_pick_addr = '0;
    for (int i = 0; i < int'(N_CORES); i++) begin
      if (w_grant[i]) begin
        w_pick_idx  = SRC_W'(i);
        w_pick_op   = bus_op_t'(i_req_type[2*i +: 2]);
        w_pick_addr = i_req_addr[ADDR_W*i +: ADDR_W];
      end
    end
  end

  // The originating core never answers its own snoop, so it counts as acked.
  assign w_req_any    = |i_req_valid;
  assign w_src_mask   = N_CORES'(1) << r_src;
  assign w_ack_all    = &(r_ack | i_snoop_ack | w_src_mask);
  assign w_abort_any  = |((r_abort | i_snoop_abort) & ~w_src_mask);
  assign w_snoop_exit = w_ack_all || w_timeout;

  assign w_mem_write_nxt = (r_state == ST_IDLE) ? (w_pick_op == WRITE_BACK) : (r_op == WRITE_BACK);
  assign w_mem_addr_nxt  = (r_state == ST_IDLE) ? w_pick_addr : r_addr;

`ifdef COHBUS_TIMEOUT_EN
  localparam int unsigned TCNT_W = $clog2(TIMEOUT + 1);

  logic [TCNT_W-1:0] r_tcnt;
  logic              r_terr;

  assign w_timeout = (r_state == ST_SNOOP) && !w_ack_all && (r_tcnt == TCNT_W'(TIMEOUT - 1));

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_tcnt <= '0;
      r_terr <= 1'b0;
    end else begin
      r_tcnt <= (r_state == ST_SNOOP && w_next == ST_SNOOP) ? r_tcnt + 1'b1 : '0;
      if (w_timeout) r_terr <= 1'b1;
    end
  end

  assign o_timeout_err = r_terr;
`else
  logic w_unused_timeout;

  assign w_timeout        = 1'b0;
  assign w_unused_timeout = (TIMEOUT == 0);
  assign o_timeout_err    = 1'b0;
`endif

  always_ff @(posedge i_clock) begin
    if (i_reset) r_state <= ST_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_req_any) w_next = (w_pick_op == WRITE_BACK) ? ST_MEM : ST_SNOOP;
      end
      ST_SNOOP: begin
        // An abort means a Modified owner supplies the block; invalidates never touch memory.
        if (w_snoop_exit) begin
          w_next = (r_op == INVALIDATE || w_abort_any) ? ST_DONE : ST_MEM;
        end
      end
      ST_MEM: begin
        if (i_mem_done) w_next = ST_DONE;
      end
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_src         <= '0;
      r_last        <= SRC_W'(N_CORES - 1);
      r_op          <= READ_MISS;
      r_addr        <= '0;
      r_ack         <= '0;
      r_abort       <= '0;
      r_grant       <= '0;
      r_done        <= '0;
      r_snoop_valid <= 1'b0;
      r_mem_req     <= 1'b0;
      r_mem_write   <= 1'b0;
      r_mem_addr    <= '0;
      r_busy        <= 1'b0;
    end else begin
      if (r_state == ST_IDLE && w_req_any) begin
        r_src  <= w_pick_idx;
        r_op   <= w_pick_op;
        r_addr <= w_pick_addr;
      end
      if (r_state == ST_SNOOP && w_next == ST_SNOOP) begin
        r_ack   <= (r_ack | i_snoop_ack) & ~w_src_mask;
        r_abort <= (r_abort | i_snoop_abort) & ~w_src_mask;
      end else begin
        r_ack   <= '0;
        r_abort <= '0;
      end
      r_grant       <= (r_state == ST_IDLE) ? w_grant : '0;
      r_done        <= (r_state == ST_DONE) ? w_src_mask : '0;
      if (r_state == ST_DONE) r_last <= r_src;
      r_snoop_valid <= (w_next == ST_SNOOP);
      r_mem_req     <= (w_next == ST_MEM);
      r_mem_write   <= (w_next == ST_MEM) && w_mem_write_nxt;
      r_mem_addr    <= (w_next == ST_MEM) ? w_mem_addr_nxt : '0;
      r_busy        <= (w_next != ST_IDLE);
    end
  end

  assign o_req_grant   = r_grant;
  assign o_req_done    = r_done;
  assign o_snoop_valid = r_snoop_valid;
  assign o_snoop_type  = 2'(r_op);
  assign o_snoop_addr  = r_addr;
  assign o_snoop_src   = r_src;
  assign o_mem_req     = r_mem_req;
  assign o_mem_write   = r_mem_write;
  assign o_mem_addr    = r_mem_addr;
  assign o_bus_busy    = r_busy;

endmodule

// File: tb/tb_coherence_bus.sv
// Scoreboard bench for coherence_bus: stimulus queues expected events, a negedge monitor checks them.
module tb_coherence_bus;

  localparam int unsigned N  = 4;
  localparam int unsigned AW = 8;
  localparam int unsigned TO = 16;

  localparam logic [1:0] OP_RM = 2'b00;
  localparam logic [1:0] OP_WM = 2'b01;
  localparam logic [1:0] OP_IV = 2'b10;
  localparam logic [1:0] OP_WB = 2'b11;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req_valid;
  logic [2*N-1:0]  req_type;
  logic [AW*N-1:0] req_addr;
  logic [N-1:0]  grant, done;
  logic          snoop_valid;
  logic [1:0]    snoop_type;
  logic [AW-1:0] snoop_addr;
  logic [1:0]    snoop_src;
  logic [N-1:0]  snoop_ack, snoop_abort;
  logic          mem_req, mem_write, mem_done;
  logic [AW-1:0] mem_addr;
  logic          bus_busy, timeout_err;

  coherence_bus #(.N_CORES(N), .ADDR_W(AW), .TIMEOUT(TO)) dut (
    .i_clock       (clk),
    .i_reset       (rst),
    .i_req_valid   (req_valid),
    .i_req_type    (req_type),
    .i_req_addr    (req_addr),
    .o_req_grant   (grant),
    .o_req_done    (done),
    .o_snoop_valid (snoop_valid),
    .o_snoop_type  (snoop_type),
    .o_snoop_addr  (snoop_addr),
    .o_snoop_src   (snoop_src),
    .i_snoop_ack   (snoop_ack),
    .i_snoop_abort (snoop_abort),
    .o_mem_req     (mem_req),
    .o_mem_write   (mem_write),
    .o_mem_addr    (mem_addr),
    .i_mem_done    (mem_done),
    .o_bus_busy    (bus_busy),
    .o_timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int core; int cyc; } ev_t;
  typedef struct { logic [1:0] op; logic [7:0] addr; logic [1:0] src; } snp_t;
  typedef struct { logic wr; logic [7:0] addr; } mem_t;
  typedef struct { string name; logic [39:0] v; } probe_t;

  ev_t    grant_q[$];
  ev_t    done_q[$];
  snp_t   snoop_q[$];
  mem_t   mem_q[$];
  probe_t probe_q[$];

  int   total = 0;
  int   bad   = 0;
  int   stim_fails = 0;
  bit   finish_req = 1'b0;
  logic prev_sv = 1'b0;
  logic prev_mr = 1'b0;

  logic [N-1:0] ack_en, abort_en;
  logic         mem_auto;

  function automatic logic [39:0] mk_snap(input logic busy, input logic sv, input logic mr,
                                          input logic mw, input logic te, input logic [3:0] g,
                                          input logic [3:0] d, input logic [7:0] ma,
                                          input logic [1:0] st, input logic [7:0] sa,
                                          input logic [1:0] ss);
    return {7'b0, busy, sv, mr, mw, te, g, d, ma, st, sa, ss};
  endfunction

  task automatic cmp(input string name, input logic [39:0] act, input logic [39:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops the expectation matching whatever the DUT presents this cycle.
  always @(negedge clk) begin
    ev_t    e;
    snp_t   s;
    mem_t   m;
    probe_t p;
    if (grant != '0) begin
      if (grant_q.size() == 0) cmp("grant_unexpected", 40'(grant), 40'(0));
      else begin
        e = grant_q.pop_front();
        cmp("grant_core", 40'(grant), 40'(4'(1) << e.core));
        if (e.cyc >= 0) cmp("grant_cycle", 40'(cyc), 40'(e.cyc));
      end
    end
    if (done != '0) begin
      if (done_q.size() == 0) cmp("done_unexpected", 40'(done), 40'(0));
      else begin
        e = done_q.pop_front();
        cmp("done_core", 40'(done), 40'(4'(1) << e.core));
        if (e.cyc >= 0) cmp("done_cycle", 40'(cyc), 40'(e.cyc));
      end
    end
    if (snoop_valid && !prev_sv) begin
      if (snoop_q.size() == 0) cmp("snoop_unexpected", 40'(snoop_valid), 40'(0));
      else begin
        s = snoop_q.pop_front();
        cmp("snoop_fields", 40'({snoop_type, snoop_addr, snoop_src}), 40'({s.op, s.addr, s.src}));
      end
    end
    if (mem_req && !prev_mr) begin
      if (mem_q.size() == 0) cmp("mem_unexpected", 40'(mem_req), 40'(0));
      else begin
        m = mem_q.pop_front();
        cmp("mem_fields", 40'({mem_write, mem_addr}), 40'({m.wr, m.addr}));
      end
    end
    if (probe_q.size() > 0) begin
      p = probe_q.pop_front();
      cmp(p.name, mk_snap(bus_busy, snoop_valid, mem_req, mem_write, timeout_err, grant, done,
                          mem_addr, snoop_type, snoop_addr, snoop_src), p.v);
    end
    prev_sv = snoop_valid;
    prev_mr = mem_req;
    if (finish_req) begin
      cmp("grant_q_left", 40'(grant_q.size()), 40'(0));
      cmp("done_q_left",  40'(done_q.size()),  40'(0));
      cmp("snoop_q_left", 40'(snoop_q.size()), 40'(0));
      cmp("mem_q_left",   40'(mem_q.size()),   40'(0));
      cmp("stim_waits",   40'(stim_fails),     40'(0));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
    end
  end

  // Advance one cycle, then play the cores and memory for the new cycle.
  task automatic step();
    @(posedge clk);
    #1;
    snoop_ack   = snoop_valid ? ack_en : '0;
    snoop_abort = snoop_valid ? abort_en : '0;
    mem_done    = mem_req & mem_auto;
    req_valid   = req_valid & ~grant;
  endtask

  task automatic issue(input int core, input logic [1:0] op, input logic [7:0] addr,
                       input int g_off, input int d_off, input bit snp, input bit has_mem,
                       input bit has_done);
    ev_t e;
    req_valid[core]           = 1'b1;
    req_type[2*core +: 2]     = op;
    req_addr[AW*core +: AW]   = addr;
    e.core = core;
    e.cyc  = (g_off < 0) ? -1 : cyc + g_off;
    grant_q.push_back(e);
    if (has_done) begin
      e.cyc = (d_off < 0) ? -1 : cyc + d_off;
      done_q.push_back(e);
    end
    if (snp) snoop_q.push_back('{op, addr, 2'(core)});
    if (has_mem) mem_q.push_back('{op == OP_WB, addr});
  endtask

  task automatic probe(input string name, input logic [39:0] v);
    probe_t p;
    p.name = name;
    p.v    = v;
    probe_q.push_back(p);
  endtask

  task automatic wait_idle(input string name, input int bound);
    int i = 0;
    while (i < bound && !(!bus_busy && req_valid == '0 && done_q.size() == 0)) begin
      step();
      i++;
    end
    if (!(!bus_busy && req_valid == '0 && done_q.size() == 0)) begin
      stim_fails++;
      $display("FAIL wait_idle %s: not idle after %0d cycles", name, bound);
    end
  endtask

  initial begin
    int k;
    rst = 1'b1; req_valid = '0; req_type = '0; req_addr = '0;
    snoop_ack = '0; snoop_abort = '0; mem_done = 1'b0;
    ack_en = '0; abort_en = '0; mem_auto = 1'b1;
    step();
    step();
    probe("reset_state", 40'(0));
    rst = 1'b0;
    step();

    // Core0 read miss, immediate acks and memory.
    ack_en = 4'hF;
    issue(0, OP_RM, 8'h12, 1, 4, 1, 1, 1);
    wait_idle("read_miss", 40);

    // Core1 holds the block Modified: no memory access.
    abort_en = 4'b0010;
    issue(2, OP_WM, 8'h05, 1, 3, 1, 0, 1);
    wait_idle("write_miss_abort", 40);

    // An abort from the requester itself does not count.
    abort_en = 4'b0001;
    issue(0, OP_RM, 8'h20, 1, 4, 1, 1, 1);
    wait_idle("src_abort_ignored", 40);

    // Invalidate never reaches memory, abort or not.
    abort_en = 4'b0010;
    issue(3, OP_IV, 8'h77, 1, 3, 1, 0, 1);
    wait_idle("invalidate", 40);
    abort_en = '0;

    // Three simultaneous requesters, then core0 again.
    issue(0, OP_RM, 8'h30, 1, 4, 1, 1, 1);
    issue(1, OP_RM, 8'h31, 5, 8, 1, 1, 1);
    issue(3, OP_RM, 8'h33, 9, 12, 1, 1, 1);
    wait_idle("round_robin", 60);
    issue(0, OP_WM, 8'h40, 1, 4, 1, 1, 1);
    wait_idle("round_robin_again", 40);

    // Write-back skips the snoop phase.
    issue(1, OP_WB, 8'hFF, 1, 3, 0, 1, 1);
    wait_idle("write_back", 40);

    // Memory stalls: bus stays in MEM holding the request.
    mem_auto = 1'b0;
    issue(2, OP_RM, 8'h60, 1, -1, 1, 1, 1);
    repeat (5) step();
    probe("mem_stall", mk_snap(1, 0, 1, 0, 0, 4'h0, 4'h0, 8'h60, OP_RM, 8'h60, 2'd2));
    mem_auto = 1'b1;
    wait_idle("mem_stall", 40);

    // Core3 withholds its ack; other acks arrive only once and must stick.
    ack_en = 4'b0111;
`ifdef COHBUS_TIMEOUT_EN
    issue(0, OP_RM, 8'h42, 1, 19, 1, 1, 1);
    step();
    ack_en = '0;
    wait_idle("snoop_timeout", 60);
    probe("timeout_flag", mk_snap(0, 0, 0, 0, 1, 4'h0, 4'h0, 8'h00, OP_RM, 8'h42, 2'd0));
    step();
`else
    issue(0, OP_RM, 8'h42, 1, -1, 1, 1, 1);
    step();
    ack_en = '0;
    repeat (38) step();
    probe("hold_no_ack", mk_snap(1, 1, 0, 0, 0, 4'h0, 4'h0, 8'h00, OP_RM, 8'h42, 2'd0));
    ack_en = 4'b1000;
    wait_idle("late_ack", 20);
`endif
    ack_en = 4'hF;

    // Reset mid-MEM abandons the transaction without a done pulse.
    mem_auto = 1'b0;
    issue(2, OP_RM, 8'h50, 1, -1, 1, 1, 0);
    k = 0;
    while (!mem_req && k < 20) begin
      step();
      k++;
    end
    if (!mem_req) begin
      stim_fails++;
      $display("FAIL wait_mem: mem_req not seen within 20 cycles");
    end
    rst = 1'b1;
    step();
    probe("reset_mid_mem", 40'(0));
    rst = 1'b0;
    mem_auto = 1'b1;
    step();

    // Reset restores core0 as first in line.
    issue(0, OP_RM, 8'h51, 1, 4, 1, 1, 1);
    issue(3, OP_RM, 8'h53, 5, 8, 1, 1, 1);
    wait_idle("post_reset_order", 60);
    step();
    finish_req = 1'b1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
